spi_slave_gen: RTL and testbench
================================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Parameters
REQ-001 SHALL have parameter MEM_DEPTH, default 256: memory depth; localparam ADDR_SIZE = clog2(MEM_DEPTH); localparam W = ADDR_SIZE+2 (frame length).
REQ-002 SHALL have parameter LSB_FIRST, default 0: 0 = payload bits shifted MSB first, 1 = LSB first (both directions).

Interface
REQ-003 SHALL have port clk  input  1  SPI bit clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port SS_n  input  1  slave select, active-low; frame = low interval.
REQ-006 SHALL have port MOSI  input  1  serial data in.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid strobe from memory side.
REQ-008 SHALL have port tx_data  input  ADDR_SIZE  read data to serialise.
REQ-009 SHALL have port MISO  output  1  serial data out.
REQ-010 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data complete.
REQ-011 SHALL have port rx_data  output  W  received frame; [W-1:W-2] = command, [W-3:0] = payload.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-013 SHALL have port frame_err  output  1  one-cycle strobe, frame aborted early.

Function
REQ-014 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA plus internal flag rd_addr_seen.
REQ-015 SHALL move IDLE->CHK_CMD on the edge sampling SS_n=0; MOSI ignored at that edge.
REQ-016 SHALL, in CHK_CMD, capture MOSI as frame bit 1 (rx_data[W-1]) and go to WRITE if 0, READ_ADD if 1 and rd_addr_seen=0, READ_DATA if 1 and rd_addr_seen=1.
REQ-017 SHALL capture one MOSI bit per edge while SS_n=0 until W bits are taken; bit 2 goes to rx_data[W-2] always.
REQ-018 SHALL place payload bits 3..W into rx_data[W-3] downward when LSB_FIRST=0, into rx_data[0] upward when LSB_FIRST=1.
REQ-019 SHALL update rx_data and assert rx_valid at the edge sampling bit W; rx_valid high exactly one cycle; rx_data holds until next completed frame.
REQ-020 SHALL ignore MOSI bits beyond W in a frame; no further rx_valid in that frame.
REQ-021 SHALL set rd_addr_seen at rx_valid of a READ_ADD frame and clear it at rx_valid of a READ_DATA frame; WRITE frames leave it unchanged.
REQ-022 SHALL, in READ_DATA after rx_valid, wait for tx_valid=1; at that edge latch tx_data into a shift register.
REQ-023 SHALL drive MISO with latched bit ADDR_SIZE-1 (LSB_FIRST=0) or bit 0 (LSB_FIRST=1) from the cycle after the latch, one bit per cycle, ADDR_SIZE bits total, then MISO=0.
REQ-024 SHALL ignore tx_valid outside READ_DATA-awaiting and during shift-out.
REQ-025 SHALL hold MISO=0 whenever not shifting.
REQ-026 SHALL return to IDLE at the edge sampling SS_n=1 from any state; bit counter and shift register cleared.
REQ-027 SHALL pulse frame_err one cycle on SS_n=1 when fewer than W bits captured, or READ_DATA shift-out incomplete (including tx_valid never received); rd_addr_seen unchanged by aborted frames.
REQ-028 SHALL give no rx_valid for an aborted frame; rx_data keeps prior value.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state IDLE, rx_valid=0, rx_data=0, MISO=0, busy=0, frame_err=0, rd_addr_seen=0, counters 0.
REQ-030 SHALL resume with IDLE on first edge after rst_n rises; reset mid-frame discards the frame with no frame_err.

Verification (MEM_DEPTH=256, W=10)
REQ-031 Write: SS_n low, MOSI 0,0,1,0,1,0,0,1,0,1 on edges 2-11 -> rx_data=10'h0A5, rx_valid high one cycle after edge 11, busy high from edge 1.
REQ-032 Read: frame 1,0,0x3C -> rx_data=10'h23C, rd_addr_seen=1; frame 1,1,0x00 then tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on next 8 cycles, rd_addr_seen=0.
REQ-033 LSB_FIRST=1: write frame 0,0 then bits 1,0,1,0,0,1,0,1 -> rx_data=10'h0A5; read tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1.
REQ-034 Abort: SS_n high after 5 bits -> frame_err one cycle, no rx_valid, rx_data unchanged, IDLE next cycle.
REQ-035 Reset mid-shift-out: rst_n low during MISO bit 4 -> MISO=0, busy=0 immediately; next full write frame received correctly.

Source files
------------

// File: rtl/spi_slave_gen.sv
// SPI slave frame engine: collects a W-bit command/payload frame on MOSI,
// tracks the read-address / read-data pairing, and serialises memory read
// data on MISO once the memory side supplies it.
//
// Handshake: tx_valid/tx_data is sampled only while a READ_DATA frame has been
// fully received and no shift-out has started yet; the first edge with
// tx_valid=1 in that window latches tx_data (an implicit ready), every other
// tx_valid is ignored. rx_valid is a one-cycle strobe with no back-pressure.
module spi_slave_gen #(
  parameter int MEM_DEPTH = 256,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           SS_n,
  input  logic                           MOSI,
  input  logic                           tx_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0]   tx_data,
  output logic                           MISO,
  output logic                           rx_valid,
  output logic [$clog2(MEM_DEPTH)+1:0]   rx_data,
  output logic                           busy,
  output logic                           frame_err
);

  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int W         = ADDR_SIZE + 2;
  localparam int CW        = $clog2(W + 1);
  localparam int TW        = $clog2(ADDR_SIZE + 1);

  localparam logic [CW-1:0] W_CNT    = CW'(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [TW-1:0] TX_LAST  = TW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q;
  logic [W-1:0]           rx_buf_q;
  logic [W-1:0]           rx_next;
  logic                   rd_addr_seen_q;
  logic [ADDR_SIZE-1:0]   tx_sh_q;
  logic [TW-1:0]          tx_cnt_q;
  logic                   shifting_q;
  logic                   tx_done_q;
  logic                   take_bit;
  logic                   tx_take;

  assign take_bit = !SS_n && (state_q != IDLE) && (bit_cnt_q != W_CNT);
  assign tx_take  = !SS_n && (state_q == READ_DATA) && (bit_cnt_q == W_CNT) &&
                    !shifting_q && !tx_done_q && tx_valid;
  assign busy     = (state_q != IDLE);
  assign MISO     = shifting_q & (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[ADDR_SIZE-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: SS_n high always ends the frame; the command bit picks the path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)                state_d = IDLE;
        else if (!MOSI)          state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Place the incoming bit: command bits fill the top, payload fills per bit order.
  always_comb begin
    int k;
    int idx;
    rx_next = rx_buf_q;
    k = int'(bit_cnt_q) + 1;
    if (k == 1)          idx = W - 1;
    else if (k == 2)     idx = W - 2;
    else if (LSB_FIRST)  idx = k - 3;
    else                 idx = W - k;
    for (int i = 0; i < W; i++) begin
      if (i == idx) rx_next[i] = MOSI;
    end
  end

  // Frame capture, read-pairing flag, shift-out and abort detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q      <= '0;
      rx_buf_q       <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      frame_err      <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_sh_q        <= '0;
      tx_cnt_q       <= '0;
      shifting_q     <= 1'b0;
      tx_done_q      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (SS_n) begin
        if (state_q != IDLE) begin
          frame_err <= (bit_cnt_q != W_CNT) || ((state_q == READ_DATA) && !tx_done_q);
        end
        bit_cnt_q  <= '0;
        rx_buf_q   <= '0;
        tx_sh_q    <= '0;
        tx_cnt_q   <= '0;
        shifting_q <= 1'b0;
        tx_done_q  <= 1'b0;
      end else begin
        if (take_bit) begin
          rx_buf_q  <= rx_next;
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_CNT) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            if (state_q == READ_ADD)  rd_addr_seen_q <= 1'b1;
            if (state_q == READ_DATA) rd_addr_seen_q <= 1'b0;
          end
        end
        if (tx_take) begin
          tx_sh_q    <= tx_data;
          tx_cnt_q   <= '0;
          shifting_q <= 1'b1;
        end else if (shifting_q) begin
          tx_sh_q  <= LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);
          tx_cnt_q <= tx_cnt_q + 1'b1;
          if (tx_cnt_q == TX_LAST) begin
            shifting_q <= 1'b0;
            tx_done_q  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: an MSB-first and an LSB-first instance share all
// inputs; received frames and frame errors are scored from expected queues.
module tb_spi_slave_gen;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       tx_valid;
  logic [7:0] tx_data;

  logic       miso0, rx_valid0, busy0, frame_err0;
  logic [9:0] rx_data0;
  logic       miso1, rx_valid1, busy1, frame_err1;
  logic [9:0] rx_data1;

  int checks   = 0;
  int failures = 0;

  logic [9:0] exp_rx0_q[$];
  logic [9:0] exp_rx1_q[$];
  logic [0:0] exp_err0_q[$];
  logic [0:0] exp_err1_q[$];

  spi_slave_gen #(.MEM_DEPTH(256), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data), .MISO(miso0),
    .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0), .frame_err(frame_err0)
  );

  spi_slave_gen #(.MEM_DEPTH(256), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data), .MISO(miso1),
    .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1), .frame_err(frame_err1)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid / frame_err strobe must match a queued expectation.
  always @(negedge clk) begin
    if (rx_valid0) begin
      if (exp_rx0_q.size() == 0) check("rx0_unexpected", 16'(rx_data0), 16'hFFFF);
      else check("rx0_data", 16'(rx_data0), 16'(exp_rx0_q.pop_front()));
    end
    if (rx_valid1) begin
      if (exp_rx1_q.size() == 0) check("rx1_unexpected", 16'(rx_data1), 16'hFFFF);
      else check("rx1_data", 16'(rx_data1), 16'(exp_rx1_q.pop_front()));
    end
    if (frame_err0) begin
      if (exp_err0_q.size() == 0) check("err0_unexpected", 16'd1, 16'd0);
      else check("err0", 16'(frame_err0), 16'(exp_err0_q.pop_front()));
    end
    if (frame_err1) begin
      if (exp_err1_q.size() == 0) check("err1_unexpected", 16'd1, 16'd0);
      else check("err1", 16'(frame_err1), 16'(exp_err1_q.pop_front()));
    end
  end

  // Lower SS_n, then drive nbits MOSI bits, first bit taken from seq[15].
  task automatic send_bits(input logic [15:0] seq, input int nbits);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);
    check("busy_after_edge1", 16'({busy0, busy1}), 16'h3);
    MOSI = seq[15];
    for (int i = 1; i < nbits; i++) begin
      @(negedge clk);
      MOSI = seq[15 - i];
    end
  endtask

  // Raise SS_n and confirm both instances are back in IDLE.
  task automatic end_frame();
    @(negedge clk);
    MOSI = 1'b0;
    SS_n = 1'b1;
    @(negedge clk);
    check("idle_after_ss", 16'({busy0, busy1}), 16'h0);
  endtask

  task automatic expect_rx(input logic [9:0] e0, input logic [9:0] e1);
    exp_rx0_q.push_back(e0);
    exp_rx1_q.push_back(e1);
  endtask

  task automatic expect_err();
    exp_err0_q.push_back(1'b1);
    exp_err1_q.push_back(1'b1);
  endtask

  // After a full frame, offer tx_data once and check the 8 MISO bits
  // (first bit in e0[7]/e1[7]). rst_at >= 0 pulses reset during that bit.
  task automatic shift_out(input logic [7:0] txd, input logic [7:0] e0,
                           input logic [7:0] e1, input int rst_at);
    @(negedge clk);
    MOSI     = 1'b0;
    tx_valid = 1'b1;
    tx_data  = txd;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("miso0_bit%0d", i), 16'(miso0), 16'(e0[7 - i]));
      check($sformatf("miso1_bit%0d", i), 16'(miso1), 16'(e1[7 - i]));
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso", 16'({miso0, miso1}), 16'h0);
        check("rst_busy", 16'({busy0, busy1}), 16'h0);
        check("rst_rx_data0", 16'(rx_data0), 16'h0);
        check("rst_rx_data1", 16'(rx_data1), 16'h0);
        @(negedge clk);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check("miso_idle_after_shift", 16'({miso0, miso1}), 16'h0);
    end_frame();
  endtask

  // Directed sequence.
  initial begin
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_rx_data0", 16'(rx_data0), 16'h0);
    check("reset_rx_data1", 16'(rx_data1), 16'h0);
    check("reset_strobes", 16'({rx_valid0, rx_valid1, frame_err0, frame_err1}), 16'h0);
    check("reset_miso_busy", 16'({miso0, miso1, busy0, busy1}), 16'h0);
    rst_n = 1'b1;

    // Write 0,0,A5 (A5 is a bit palindrome, so both orders give 0A5).
    expect_rx(10'h0A5, 10'h0A5);
    send_bits({2'b00, 8'hA5, 6'b0}, 10);
    end_frame();

    // Write 0,0,C1: LSB-first instance sees the payload reversed (0x83).
    expect_rx(10'h0C1, 10'h083);
    send_bits({2'b00, 8'hC1, 6'b0}, 10);
    end_frame();

    // Read address 1,0,3C then read data with tx C3.
    expect_rx(10'h23C, 10'h23C);
    send_bits({2'b10, 8'h3C, 6'b0}, 10);
    end_frame();
    expect_rx(10'h300, 10'h300);
    send_bits({2'b11, 8'h00, 6'b0}, 10);
    shift_out(8'hC3, 8'hC3, 8'hC3, -1);

    // Read address 1,0,12 (LSB-first: 0x48) then read data with tx 1E.
    expect_rx(10'h212, 10'h248);
    send_bits({2'b10, 8'h12, 6'b0}, 10);
    end_frame();
    expect_rx(10'h300, 10'h300);
    send_bits({2'b11, 8'h00, 6'b0}, 10);
    shift_out(8'h1E, 8'h1E, 8'h78, -1);

    // Pairing flag cleared: a 1,1 frame is now a read-address, MISO stays low.
    expect_rx(10'h300, 10'h300);
    send_bits({2'b11, 8'h00, 6'b0}, 10);
    shift_out(8'hFF, 8'h00, 8'h00, -1);

    // Abort after 5 bits: frame_err only, rx_data unchanged.
    expect_err();
    send_bits({5'b00111, 11'b0}, 5);
    end_frame();
    check("abort_rx_data0", 16'(rx_data0), 16'h300);
    check("abort_rx_data1", 16'(rx_data1), 16'h300);

    // 12 bits: the two extra bits are ignored, one rx_valid.
    expect_rx(10'h196, 10'h169);
    send_bits({2'b01, 8'h96, 2'b11, 4'b0}, 12);
    end_frame();

    // Read data frame (flag set by the earlier 1,1 frame) with no tx_valid.
    expect_rx(10'h300, 10'h300);
    expect_err();
    send_bits({2'b11, 8'h00, 6'b0}, 10);
    repeat (3) @(negedge clk);
    check("no_tx_miso", 16'({miso0, miso1}), 16'h0);
    end_frame();

    // Reset during MISO bit 4 of a read.
    expect_rx(10'h23C, 10'h23C);
    send_bits({2'b10, 8'h3C, 6'b0}, 10);
    end_frame();
    expect_rx(10'h300, 10'h300);
    send_bits({2'b11, 8'h00, 6'b0}, 10);
    shift_out(8'hC3, 8'hC3, 8'hC3, 3);

    // Next full write frame after reset.
    expect_rx(10'h0C1, 10'h083);
    send_bits({2'b00, 8'hC1, 6'b0}, 10);
    end_frame();

    repeat (3) @(negedge clk);
    check("rx0_queue_drained", 16'(exp_rx0_q.size()), 16'h0);
    check("rx1_queue_drained", 16'(exp_rx1_q.size()), 16'h0);
    check("err0_queue_drained", 16'(exp_err0_q.size()), 16'h0);
    check("err1_queue_drained", 16'(exp_err1_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
